// File: rtl/sonic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sonic_pkg                                                        |
// | Brief   : Shared constants, FSM state encoding and helpers for sonic_ranger|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sonic_pkg;

  localparam int TRIG_CYCLES_DEF  = 500;
  localparam int CYC_PER_UNIT_DEF = 290;
  localparam int MAX_UNITS_DEF    = 4000;
  localparam int RISE_TIMEOUT_DEF = 1000000;
  localparam int DEGLITCH_LEN     = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_TRIG      = 2'd1;
  localparam logic [1:0] ST_WAIT_RISE = 2'd2;
  localparam logic [1:0] ST_ECHO      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_TRIG      = ST_TRIG,
    S_WAIT_RISE = ST_WAIT_RISE,
    S_ECHO      = ST_ECHO
  } sonic_state_e;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sonic_echo_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sonic_echo_sync                                                  |
// | Brief   : ECHO pin synchroniser with rise/fall pulses; optional deglitch   |
// |           filter enabled by SONIC_DEGLITCH_EN.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sonic_echo_sync
  import sonic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic echo_i,
  output logic echo_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic echo_s;
  logic echo_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= echo_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SONIC_DEGLITCH_EN
  localparam int GW = cnt_width(DEGLITCH_LEN);

  logic          filt_q;
  logic          filt_d;
  logic [GW-1:0] glitch_cnt_q;
  logic [GW-1:0] glitch_cnt_d;

  // The filtered level follows only after DEGLITCH_LEN consecutive differing samples.
  always_comb begin
    filt_d       = filt_q;
    glitch_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (glitch_cnt_q == GW'(DEGLITCH_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        glitch_cnt_d = glitch_cnt_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q       <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      filt_q       <= filt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign echo_s = filt_q;
`else
  assign echo_s = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_prev_q <= 1'b0;
    end else begin
      echo_prev_q <= echo_s;
    end
  end

  assign echo_s_o = echo_s;
  assign rise_o   = echo_s & ~echo_prev_q;
  assign fall_o   = ~echo_s & echo_prev_q;

endmodule
`default_nettype wire

// File: rtl/sonic_ranger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sonic_ranger                                                     |
// | Brief   : Ultrasonic range-finder front end: trigger pulse, echo timing,   |
// |           quantised distance or fail. SONIC_DEGLITCH_EN adds echo filter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sonic_ranger
  import sonic_pkg::*;
#(
  parameter int DisLen       = 16,
  parameter int TRIG_CYCLES  = TRIG_CYCLES_DEF,
  parameter int CYC_PER_UNIT = CYC_PER_UNIT_DEF,
  parameter int MAX_UNITS    = MAX_UNITS_DEF,
  parameter int RISE_TIMEOUT = RISE_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trigger,
  output logic            triggerSuc,
  output logic            valid,
  output logic            fail,
  output logic [DisLen:0] distance,
  output logic            sonic_trig,
  input  logic            sonic_echo
);

  localparam int DW = DisLen + 1;
  localparam int TW = cnt_width(TRIG_CYCLES);
  localparam int PW = cnt_width(CYC_PER_UNIT);
  localparam int WW = $clog2(RISE_TIMEOUT + 1);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CYC_PER_UNIT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RISE_TIMEOUT - 1);
  localparam logic [DW-1:0] UNIT_MAX  = DW'(MAX_UNITS);

  logic echo_s;
  logic echo_rise;
  logic echo_fall;

  sonic_echo_sync u_echo_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .echo_i   (sonic_echo),
    .echo_s_o (echo_s),
    .rise_o   (echo_rise),
    .fall_o   (echo_fall)
  );

  sonic_state_e  state_q, state_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [DW-1:0] unit_cnt_q, unit_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] distance_q, distance_d;
  logic          sonic_trig_q, sonic_trig_d;
  logic          trig_suc_q, trig_suc_d;
  logic          valid_q, valid_d;
  logic          fail_q, fail_d;
  logic [PW-1:0] pre_inc;
  logic [DW-1:0] unit_inc;

  // The fall cycle itself is counted, so an echo of N cycles yields N/CYC_PER_UNIT.
  assign pre_inc  = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PW'(1);
  assign unit_inc = (pre_cnt_q == PRE_LAST) ? unit_cnt_q + DW'(1) : unit_cnt_q;

  always_comb begin
    state_d      = state_q;
    trig_cnt_d   = trig_cnt_q;
    pre_cnt_d    = pre_cnt_q;
    unit_cnt_d   = unit_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    distance_d   = distance_q;
    sonic_trig_d = sonic_trig_q;
    trig_suc_d   = 1'b0;
    valid_d      = 1'b0;
    fail_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger && !echo_s) begin
          state_d      = S_TRIG;
          sonic_trig_d = 1'b1;
          trig_cnt_d   = '0;
        end
      end
      S_TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          sonic_trig_d = 1'b0;
          trig_suc_d   = 1'b1;
          wait_cnt_d   = '0;
          state_d      = S_WAIT_RISE;
        end else begin
          trig_cnt_d = trig_cnt_q + TW'(1);
        end
      end
      S_WAIT_RISE: begin
        if (echo_rise) begin
          pre_cnt_d  = '0;
          unit_cnt_d = '0;
          state_d    = S_ECHO;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_ECHO: begin
        pre_cnt_d  = pre_inc;
        unit_cnt_d = unit_inc;
        if (echo_fall) begin
          distance_d = unit_inc;
          valid_d    = 1'b1;
          state_d    = S_IDLE;
        end else if (unit_inc == UNIT_MAX) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      trig_cnt_q   <= '0;
      pre_cnt_q    <= '0;
      unit_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      distance_q   <= '0;
      sonic_trig_q <= 1'b0;
      trig_suc_q   <= 1'b0;
      valid_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_cnt_q   <= trig_cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      unit_cnt_q   <= unit_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      distance_q   <= distance_d;
      sonic_trig_q <= sonic_trig_d;
      trig_suc_q   <= trig_suc_d;
      valid_q      <= valid_d;
      fail_q       <= fail_d;
    end
  end

  assign triggerSuc = trig_suc_q;
  assign valid      = valid_q;
  assign fail       = fail_q;
  assign distance   = distance_q;
  assign sonic_trig = sonic_trig_q;

endmodule
`default_nettype wire
